// File: rtl/io_bus_pkg.sv
// Shared types and the default I/O map for the bus controller.
// Channel 0 sits in the least-significant bits of the packed defaults.
package io_bus_pkg;

  localparam int unsigned NUM_CS_MAX = 16;
  localparam int unsigned CPU_AW     = 20;
  localparam int unsigned DW         = 8;
  localparam int unsigned IO_AW_DEF  = 16;
  localparam int unsigned WS_W_DEF   = 4;
  localparam int unsigned NUM_CS_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } io_state_t;

  localparam logic [IO_AW_DEF-1:0] IO_BASE_0 = 16'h0000;
  localparam logic [IO_AW_DEF-1:0] IO_BASE_1 = 16'h0020;
  localparam logic [IO_AW_DEF-1:0] IO_BASE_2 = 16'h0040;
  localparam logic [IO_AW_DEF-1:0] IO_BASE_3 = 16'h0060;
  localparam logic [IO_AW_DEF-1:0] IO_BASE_4 = 16'h0080;
  localparam logic [IO_AW_DEF-1:0] IO_BASE_5 = 16'h03F8;

  localparam logic [IO_AW_DEF-1:0] IO_MASK_0 = 16'hFFF0;
  localparam logic [IO_AW_DEF-1:0] IO_MASK_1 = 16'hFFFE;
  localparam logic [IO_AW_DEF-1:0] IO_MASK_2 = 16'hFFFC;
  localparam logic [IO_AW_DEF-1:0] IO_MASK_3 = 16'hFFFC;
  localparam logic [IO_AW_DEF-1:0] IO_MASK_4 = 16'hFFF0;
  localparam logic [IO_AW_DEF-1:0] IO_MASK_5 = 16'hFFF8;

  localparam logic [WS_W_DEF-1:0] IO_WAIT_0 = 4'd1;
  localparam logic [WS_W_DEF-1:0] IO_WAIT_1 = 4'd0;
  localparam logic [WS_W_DEF-1:0] IO_WAIT_2 = 4'd1;
  localparam logic [WS_W_DEF-1:0] IO_WAIT_3 = 4'd0;
  localparam logic [WS_W_DEF-1:0] IO_WAIT_4 = 4'd0;
  localparam logic [WS_W_DEF-1:0] IO_WAIT_5 = 4'd2;

  localparam logic [NUM_CS_DEF*IO_AW_DEF-1:0] IO_BASE_DEF =
    {IO_BASE_5, IO_BASE_4, IO_BASE_3, IO_BASE_2, IO_BASE_1, IO_BASE_0};
  localparam logic [NUM_CS_DEF*IO_AW_DEF-1:0] IO_MASK_DEF =
    {IO_MASK_5, IO_MASK_4, IO_MASK_3, IO_MASK_2, IO_MASK_1, IO_MASK_0};
  localparam logic [NUM_CS_DEF*WS_W_DEF-1:0] IO_WAIT_DEF =
    {IO_WAIT_5, IO_WAIT_4, IO_WAIT_3, IO_WAIT_2, IO_WAIT_1, IO_WAIT_0};

endpackage

// File: rtl/io_bus_ctrl_if.sv
// CPU-side and peripheral-side signals of the I/O bus controller.
// master: CPU plus peripherals; slave: the controller itself.
interface io_bus_ctrl_if
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_CS = 6,
  parameter int unsigned LA_W   = 3
);

  logic                   cpu_iom;
  logic                   cpu_rd_n;
  logic                   cpu_wr_n;
  logic                   cpu_inta_n;
  logic [CPU_AW-1:0]      cpu_addr;
  logic [DW-1:0]          cpu_dout;
  logic [DW-1:0]          cpu_din;
  logic                   cpu_ready;
  logic [NUM_CS-1:0]      cs_n;
  logic                   iorc_n;
  logic                   iowc_n;
  logic [LA_W-1:0]        per_addr;
  logic [DW-1:0]          per_din;
  logic [NUM_CS*DW-1:0]   per_dout;
  logic                   per_inta_n;
  logic                   bus_err;

  modport master (
    output cpu_iom, cpu_rd_n, cpu_wr_n, cpu_inta_n, cpu_addr, cpu_dout, per_dout,
    input  cpu_din, cpu_ready, cs_n, iorc_n, iowc_n, per_addr, per_din,
           per_inta_n, bus_err
  );

  modport slave (
    input  cpu_iom, cpu_rd_n, cpu_wr_n, cpu_inta_n, cpu_addr, cpu_dout, per_dout,
    output cpu_din, cpu_ready, cs_n, iorc_n, iowc_n, per_addr, per_din,
           per_inta_n, bus_err
  );

endinterface

// File: rtl/io_addr_dec.sv
// Priority base/mask matcher: the lowest-index matching channel wins.
module io_addr_dec #(
  parameter int unsigned NUM_CS = 6,
  parameter int unsigned IO_AW  = 16,
  parameter int unsigned CH_W   = 3,
  parameter logic [NUM_CS*IO_AW-1:0] CS_BASE = '0,
  parameter logic [NUM_CS*IO_AW-1:0] CS_MASK = '0
) (
  input  logic [IO_AW-1:0] addr_i,
  output logic             hit_o,
  output logic [CH_W-1:0]  ch_idx_o
);

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    hit_o    = 1'b0;
    ch_idx_o = '0;
    for (int i = int'(NUM_CS) - 1; i >= 0; i--) begin
      if ((addr_i & CS_MASK[i*IO_AW +: IO_AW]) == CS_BASE[i*IO_AW +: IO_AW]) begin
        hit_o    = 1'b1;
        ch_idx_o = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// I/O cycle controller: decodes CPU I/O cycles to chip-selects, inserts
// per-channel wait states, registers read data and flags bad cycles.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int unsigned NUM_CS  = 6,
  parameter int unsigned IO_AW   = 16,
  parameter int unsigned LA_W    = 3,
  parameter int unsigned WS_W    = 4,
  parameter logic [NUM_CS*IO_AW-1:0] CS_BASE = IO_BASE_DEF,
  parameter logic [NUM_CS*IO_AW-1:0] CS_MASK = IO_MASK_DEF,
  parameter logic [NUM_CS*WS_W-1:0]  CS_WAIT = IO_WAIT_DEF,
  parameter int unsigned INTA_CH = 1
) (
  input  logic            clk,
  input  logic            rst,
  io_bus_ctrl_if.slave    bus
);

  localparam int unsigned CH_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  io_state_t          state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               wr_q, wr_d;
  logic               sel_q, sel_d;
  logic [WS_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]      din_q, din_d;
  logic [LA_W-1:0]    paddr_q, paddr_d;
  logic [DW-1:0]      pdin_q, pdin_d;
  logic               err_q, err_d;
  logic [NUM_CS-1:0]  cs_n_q, cs_n_d;
  logic               iorc_n_q, iorc_n_d;
  logic               iowc_n_q, iowc_n_d;
  logic               ready_q, ready_d;

  logic               hit_c;
  logic [CH_W-1:0]    ch_idx_c;
  logic [WS_W-1:0]    wait_c;
  logic [DW-1:0]      rd_data_c;
  logic               strb_idle_c;
  logic               start_c;
  logic               unused_addr_c;

  io_addr_dec #(
    .NUM_CS  (NUM_CS),
    .IO_AW   (IO_AW),
    .CH_W    (CH_W),
    .CS_BASE (CS_BASE),
    .CS_MASK (CS_MASK)
  ) u_dec (
    .addr_i   (bus.cpu_addr[IO_AW-1:0]),
    .hit_o    (hit_c),
    .ch_idx_o (ch_idx_c)
  );

  assign unused_addr_c = ^bus.cpu_addr[CPU_AW-1:IO_AW];
  assign strb_idle_c   = bus.cpu_rd_n & bus.cpu_wr_n;
  assign start_c       = bus.cpu_iom & ~strb_idle_c;

  // Wait count of the decoded channel and read data of the latched channel.
  always_comb begin
    wait_c    = '0;
    rd_data_c = 8'hFF;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (ch_idx_c == CH_W'(i)) wait_c = CS_WAIT[i*WS_W +: WS_W];
      if (ch_q == CH_W'(i))     rd_data_c = bus.per_dout[i*DW +: DW];
    end
  end

  // Next state, datapath and next-output decode.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wr_d    = wr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    paddr_d = paddr_q;
    pdin_d  = pdin_q;
    err_d   = 1'b0;

    if (!bus.cpu_inta_n) din_d = bus.per_dout[INTA_CH*DW +: DW];

    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          if (hit_c && (bus.cpu_rd_n ^ bus.cpu_wr_n)) begin
            state_d = ST_ACCESS;
            ch_d    = ch_idx_c;
            wr_d    = ~bus.cpu_wr_n;
            sel_d   = 1'b1;
            cnt_d   = wait_c;
            paddr_d = bus.cpu_addr[LA_W-1:0];
            pdin_d  = bus.cpu_dout;
          end else begin
            state_d = ST_HOLD;
            sel_d   = 1'b0;
            din_d   = 8'hFF;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (strb_idle_c) begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
          err_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WS_W'(1);
        end else begin
          if (!wr_q) din_d = rd_data_c;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (strb_idle_c) begin
          state_d = ST_IDLE;
          sel_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
      end
    endcase

    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_n_d[i] = ~(sel_d && (ch_d == CH_W'(i)));
    end
    iorc_n_d = ~(sel_d & ~wr_d);
    iowc_n_d = ~(sel_d & wr_d);
    ready_d  = ~((state_d == ST_ACCESS) && (cnt_d != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      wr_q     <= 1'b0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      din_q    <= 8'hFF;
      paddr_q  <= '0;
      pdin_q   <= '0;
      err_q    <= 1'b0;
      cs_n_q   <= '1;
      iorc_n_q <= 1'b1;
      iowc_n_q <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      paddr_q  <= paddr_d;
      pdin_q   <= pdin_d;
      err_q    <= err_d;
      cs_n_q   <= cs_n_d;
      iorc_n_q <= iorc_n_d;
      iowc_n_q <= iowc_n_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.cpu_din    = din_q;
  assign bus.cpu_ready  = ready_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.iorc_n     = iorc_n_q;
  assign bus.iowc_n     = iowc_n_q;
  assign bus.per_addr   = paddr_q;
  assign bus.per_din    = pdin_q;
  assign bus.bus_err    = err_q;
  assign bus.per_inta_n = bus.cpu_inta_n;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: a cycle-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_io_bus_ctrl;

  localparam int NCH  = 6;
  localparam int INTA = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_bus_ctrl_if #(.NUM_CS(NCH), .LA_W(3)) bus ();

  io_bus_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] base_tbl [NCH] = '{16'h0000, 16'h0020, 16'h0040, 16'h0060, 16'h0080, 16'h03F8};
  logic [15:0] mask_tbl [NCH] = '{16'hFFF0, 16'hFFFE, 16'hFFFC, 16'hFFFC, 16'hFFF0, 16'hFFF8};
  int          wait_tbl [NCH] = '{1, 0, 1, 0, 0, 2};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks the cycle in progress by age since detection.
  bit       m_active, m_miss, m_done, m_wr;
  int       m_chan, m_age, m_wlen, hit;
  logic [7:0] exp_din, exp_pdin;
  logic [2:0] exp_paddr;
  logic       exp_err;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_miss = 0; m_done = 0; m_wr = 0; m_age = 0; m_chan = 0; m_wlen = 0;
      exp_din = 8'hFF; exp_paddr = '0; exp_pdin = '0; exp_err = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (!bus.cpu_inta_n) exp_din = bus.per_dout[INTA*8 +: 8];
      if (!m_active) begin
        if (bus.cpu_iom && !(bus.cpu_rd_n && bus.cpu_wr_n)) begin
          hit = -1;
          for (int c = NCH - 1; c >= 0; c--)
            if ((bus.cpu_addr[15:0] & mask_tbl[c]) == base_tbl[c]) hit = c;
          m_active = 1;
          m_age    = 0;
          if (hit >= 0 && (bus.cpu_rd_n != bus.cpu_wr_n)) begin
            m_miss = 0; m_done = 0; m_chan = hit; m_wr = !bus.cpu_wr_n;
            m_wlen = wait_tbl[hit];
            exp_paddr = bus.cpu_addr[2:0];
            exp_pdin  = bus.cpu_dout;
          end else begin
            m_miss = 1; m_done = 1; exp_din = 8'hFF; exp_err = 1'b1;
          end
        end
      end else if (bus.cpu_rd_n && bus.cpu_wr_n) begin
        if (!m_done) exp_err = 1'b1;
        m_active = 0;
      end else if (!m_done) begin
        m_age++;
        if (m_age == m_wlen + 1) begin
          m_done = 1;
          if (!m_wr) exp_din = bus.per_dout[m_chan*8 +: 8];
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  logic [NCH-1:0] exp_cs;
  bit             sel;
  always @(posedge clk) begin
    #1;
    sel    = m_active && !m_miss;
    exp_cs = '1;
    if (sel) exp_cs[m_chan] = 1'b0;
    check("cs_n",       32'(bus.cs_n),      32'(exp_cs));
    check("iorc_n",     32'(bus.iorc_n),    32'(!(sel && !m_wr)));
    check("iowc_n",     32'(bus.iowc_n),    32'(!(sel && m_wr)));
    check("cpu_ready",  32'(bus.cpu_ready), 32'(!(m_active && !m_done && m_age < m_wlen)));
    check("cpu_din",    32'(bus.cpu_din),   32'(exp_din));
    check("per_addr",   32'(bus.per_addr),  32'(exp_paddr));
    check("per_din",    32'(bus.per_din),   32'(exp_pdin));
    check("bus_err",    32'(bus.bus_err),   32'(exp_err));
    check("per_inta_n", 32'(bus.per_inta_n), 32'(bus.cpu_inta_n));
  end

  task automatic drive_io(input logic [19:0] addr, input bit rd, input bit wr, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_iom  = 1'b1;
    bus.cpu_addr = addr;
    bus.cpu_rd_n = !rd;
    bus.cpu_wr_n = !wr;
    bus.cpu_dout = d;
  endtask

  task automatic release_io();
    bus.cpu_iom  = 1'b0;
    bus.cpu_rd_n = 1'b1;
    bus.cpu_wr_n = 1'b1;
  endtask

  int lows;

  initial begin
    bus.cpu_iom = 1'b0; bus.cpu_rd_n = 1'b1; bus.cpu_wr_n = 1'b1; bus.cpu_inta_n = 1'b1;
    bus.cpu_addr = '0; bus.cpu_dout = '0;
    bus.per_dout = {8'h77, 8'h66, 8'h5A, 8'hC3, 8'h08, 8'h11};
    repeat (2) @(negedge clk);
    check("rst_cs_n",  32'(bus.cs_n),      32'h3F);
    check("rst_din",   32'(bus.cpu_din),   32'hFF);
    check("rst_ready", 32'(bus.cpu_ready), 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Read 0x0061: channel 3 (0x60/FFFC), zero wait states.
    drive_io(20'h00061, 1, 0, 8'h00);
    @(negedge clk);
    check("rd61_cs_n",   32'(bus.cs_n),      32'b110111);
    check("rd61_iorc",   32'(bus.iorc_n),    32'h0);
    check("rd61_paddr",  32'(bus.per_addr),  32'h1);
    check("rd61_ready",  32'(bus.cpu_ready), 32'h1);
    @(negedge clk);
    check("rd61_din",    32'(bus.cpu_din),   32'h5A);
    release_io();
    @(negedge clk);
    check("rd61_rel_cs", 32'(bus.cs_n),      32'h3F);

    // Write 0x3F8 = 0x41: channel 5, two wait states.
    drive_io(20'h003F8, 0, 1, 8'h41);
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("wr_cs_n",  32'(bus.cs_n),    32'b011111);
        check("wr_iowc",  32'(bus.iowc_n),  32'h0);
        check("wr_pdin",  32'(bus.per_din), 32'h41);
      end
      if (!bus.cpu_ready) lows++;
    end
    check("wr_ready_lows", 32'(lows), 32'd2);
    release_io();
    @(negedge clk);
    check("wr_rel_cs",   32'(bus.cs_n),   32'h3F);
    check("wr_rel_iowc", 32'(bus.iowc_n), 32'h1);

    // Abort: read 0x0040 (W=1), strobe raised while still waiting.
    bus.per_dout[2*8 +: 8] = 8'hC3;
    drive_io(20'h00040, 1, 0, 8'h00);
    @(negedge clk);
    check("ab_cs_n",  32'(bus.cs_n),      32'b111011);
    check("ab_ready", 32'(bus.cpu_ready), 32'h0);
    release_io();
    @(negedge clk);
    check("ab_cs_rel", 32'(bus.cs_n),    32'h3F);
    check("ab_err",    32'(bus.bus_err), 32'h1);
    check("ab_din",    32'(bus.cpu_din), 32'h5A);
    @(negedge clk);
    check("ab_err_end", 32'(bus.bus_err), 32'h0);

    // Unmapped read 0x0300.
    drive_io(20'h00300, 1, 0, 8'h00);
    @(negedge clk);
    check("um_cs_n",  32'(bus.cs_n),      32'h3F);
    check("um_err",   32'(bus.bus_err),   32'h1);
    check("um_din",   32'(bus.cpu_din),   32'hFF);
    check("um_ready", 32'(bus.cpu_ready), 32'h1);
    @(negedge clk);
    check("um_err_end", 32'(bus.bus_err), 32'h0);
    release_io();
    repeat (2) @(negedge clk);

    // Both strobes low on a mapped address is a miss.
    drive_io(20'h00061, 1, 1, 8'h00);
    @(negedge clk);
    check("both_cs_n", 32'(bus.cs_n),    32'h3F);
    check("both_err",  32'(bus.bus_err), 32'h1);
    release_io();
    repeat (2) @(negedge clk);

    // Memory cycle is ignored.
    @(negedge clk);
    bus.cpu_addr = 20'h00061; bus.cpu_rd_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mem_cs_n",  32'(bus.cs_n),      32'h3F);
    check("mem_ready", 32'(bus.cpu_ready), 32'h1);
    release_io();
    @(negedge clk);

    // INTA returns channel 1 data.
    bus.cpu_inta_n = 1'b0;
    #1;
    check("inta_fwd", 32'(bus.per_inta_n), 32'h0);
    @(negedge clk);
    check("inta_din",  32'(bus.cpu_din), 32'h08);
    check("inta_cs_n", 32'(bus.cs_n),    32'h3F);
    bus.cpu_inta_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during the wait phase of a W=2 read.
    drive_io(20'h003FA, 1, 0, 8'h00);
    @(negedge clk);
    check("rs_ready_pre", 32'(bus.cpu_ready), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rs_cs_n",  32'(bus.cs_n),      32'h3F);
    check("rs_iorc",  32'(bus.iorc_n),    32'h1);
    check("rs_ready", 32'(bus.cpu_ready), 32'h1);
    check("rs_din",   32'(bus.cpu_din),   32'hFF);
    rst = 1'b0;
    release_io();
    repeat (3) @(negedge clk);

    // A read right after reset still works (channel 5, W=2).
    drive_io(20'h003F9, 1, 0, 8'h00);
    repeat (4) @(negedge clk);
    check("post_rs_din", 32'(bus.cpu_din),  32'h77);
    check("post_rs_pa",  32'(bus.per_addr), 32'h1);
    release_io();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
